// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared types and constants for the N-way cache controller
//
// Contents:
//   state_t    controller states CHECK / WRITEBACK / ALLOCATE / ERROR
//   MASK_*     per-way mem_mask_mux_sel encodings
//   MAX_WAYS   largest supported way count
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_CHECK     = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_ERROR     = 2'd3
  } state_t;

  localparam logic [1:0] MASK_NONE = 2'd0;
  localparam logic [1:0] MASK_LINE = 2'd1;
  localparam logic [1:0] MASK_CPU  = 2'd2;

  localparam int MAX_WAYS = 8;

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - tree pseudo-LRU state for one cache set controller
//
// Used only when CACHE_CTRL_PLRU_EN is defined.
// Ports:
//   clk, rst      clock, synchronous active-high reset (all bits cleared)
//   touch_valid   mark touch_way as most recently used this cycle
//   touch_way     way being touched
//   victim        way the tree currently points at (combinational)
module plru_tree #(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_valid,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim
);

  // Heap-ordered nodes 1..NUM_WAYS-1; children of node n are 2n and 2n+1.
  // A node bit of 0 points the victim search left, 1 points right.
  logic [NUM_WAYS-1:1] tree;
  logic [NUM_WAYS-1:1] tree_next;

  always_comb begin
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] v;
    logic             dir;
    node = WAY_W'(1);
    v    = '0;
    dir  = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir  = tree[node];
      v    = (v << 1) | WAY_W'(dir);
      node = (node << 1) | WAY_W'(dir);
    end
    victim = v;
  end

  // Walk the touched way's path, pointing every node away from it.
  always_comb begin
    logic [WAY_W-1:0] tnode;
    logic [WAY_W-1:0] tw;
    logic             tdir;
    tree_next = tree;
    tnode     = WAY_W'(1);
    tw        = touch_way;
    tdir      = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      tdir             = tw[WAY_W-1];
      tree_next[tnode] = ~tdir;
      tnode            = (tnode << 1) | WAY_W'(tdir);
      tw               = tw << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree <= '0;
    end else if (touch_valid) begin
      tree <= tree_next;
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way set-associative cache controller with pmem error handling
//
// Build option: CACHE_CTRL_PLRU_EN selects tree pseudo-LRU victims; otherwise a
// round-robin counter advanced on each completed fill. Invalid ways are always
// preferred as victims.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   mem_read, mem_write           CPU request, held until mem_resp
//   hit, valid_out, dirty_out     per-way tag match / valid / dirty of indexed set
//   pmem_resp, pmem_error         physical memory completion / failure
//   arrays_read                   constant 1
//   dirty_load/in, valid_load/in  per-way array write controls
//   tag_load                      per-way tag write
//   data_array_mux_sel            per-way 1 = CPU data, 0 = pmem line
//   mem_mask_mux_sel              2 bits per way: none / full line / CPU byte mask
//   pmem_addr_mux_sel             1 = address built from victim tag
//   victim_way                    registered victim index
//   mem_resp, mem_error           CPU completion; error qualifies resp
//   pmem_read, pmem_write         physical memory request
module cache_control_nway
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [NUM_WAYS-1:0]   hit,
  input  logic [NUM_WAYS-1:0]   valid_out,
  input  logic [NUM_WAYS-1:0]   dirty_out,
  input  logic                  pmem_resp,
  input  logic                  pmem_error,
  output logic                  arrays_read,
  output logic [NUM_WAYS-1:0]   dirty_load,
  output logic [NUM_WAYS-1:0]   dirty_in,
  output logic [NUM_WAYS-1:0]   valid_load,
  output logic [NUM_WAYS-1:0]   valid_in,
  output logic [NUM_WAYS-1:0]   tag_load,
  output logic [NUM_WAYS-1:0]   data_array_mux_sel,
  output logic [2*NUM_WAYS-1:0] mem_mask_mux_sel,
  output logic                  pmem_addr_mux_sel,
  output logic [WAY_W-1:0]      victim_way,
  output logic                  mem_resp,
  output logic                  mem_error,
  output logic                  pmem_read,
  output logic                  pmem_write
);

  state_t               state;
  logic [WAY_W-1:0]     victim_q;
  logic [NUM_WAYS-1:0]  vic_oh;
  logic                 req;
  logic                 any_hit;
  logic                 miss;
  logic                 fill_done;
  logic                 inv_found;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     policy_way;
  logic [WAY_W-1:0]     miss_way;

  assign req        = mem_read | mem_write;
  assign any_hit    = |hit;
  assign miss       = (state == ST_CHECK) && req && !any_hit;
  assign fill_done  = (state == ST_ALLOCATE) && pmem_resp && !pmem_error;
  assign vic_oh     = NUM_WAYS'(1) << victim_q;
  assign victim_way = victim_q;

  // Lowest-index invalid way; scanning downward lets the lowest index win.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_out[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
  end

  assign miss_way = inv_found ? inv_way : policy_way;

`ifdef CACHE_CTRL_PLRU_EN
  logic             touch_valid;
  logic [WAY_W-1:0] touch_way;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (hit[i]) hit_way = WAY_W'(i);
    end
  end

  // Hit responses and completed fills both count as uses.
  assign touch_valid = !rst && (((state == ST_CHECK) && req && any_hit) || fill_done);
  assign touch_way   = fill_done ? victim_q : hit_way;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .clk         (clk),
    .rst         (rst),
    .touch_valid (touch_valid),
    .touch_way   (touch_way),
    .victim      (policy_way)
  );
`else
  logic [WAY_W-1:0] rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (fill_done) begin
      rr_q <= rr_q + 1'b1;
    end
  end

  assign policy_way = rr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CHECK;
      victim_q <= '0;
    end else begin
      case (state)
        ST_CHECK: begin
          if (miss) begin
            victim_q <= miss_way;
            state    <= (valid_out[miss_way] && dirty_out[miss_way]) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          if (pmem_error)     state <= ST_ERROR;
          else if (pmem_resp) state <= ST_ALLOCATE;
        end
        ST_ALLOCATE: begin
          if (pmem_error)     state <= ST_ERROR;
          else if (pmem_resp) state <= ST_CHECK;
        end
        default: state <= ST_CHECK;
      endcase
    end
  end

  // Outputs are combinational so hits respond with zero wait states; every
  // load/request/response is held low during a reset cycle.
  always_comb begin
    arrays_read        = 1'b1;
    dirty_load         = '0;
    dirty_in           = '0;
    valid_load         = '0;
    valid_in           = '0;
    tag_load           = '0;
    data_array_mux_sel = '0;
    mem_mask_mux_sel   = '0;
    pmem_addr_mux_sel  = 1'b0;
    mem_resp           = 1'b0;
    mem_error          = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    if (!rst) begin
      case (state)
        ST_CHECK: begin
          if (mem_read && any_hit) begin
            mem_resp = 1'b1;
          end else if (mem_write && any_hit) begin
            mem_resp           = 1'b1;
            dirty_load         = hit;
            dirty_in           = hit;
            data_array_mux_sel = hit;
            for (int i = 0; i < NUM_WAYS; i++) begin
              if (hit[i]) mem_mask_mux_sel[2*i +: 2] = MASK_CPU;
            end
          end
        end
        ST_WRITEBACK: begin
          pmem_write        = 1'b1;
          pmem_addr_mux_sel = 1'b1;
          if (pmem_resp && !pmem_error) dirty_load = vic_oh;
        end
        ST_ALLOCATE: begin
          pmem_read = 1'b1;
          if (fill_done) begin
            tag_load   = vic_oh;
            valid_load = vic_oh;
            valid_in   = vic_oh;
            dirty_load = vic_oh;
            for (int i = 0; i < NUM_WAYS; i++) begin
              if (vic_oh[i]) mem_mask_mux_sel[2*i +: 2] = MASK_LINE;
            end
          end
        end
        default: begin
          mem_resp  = 1'b1;
          mem_error = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// tb/tb_cache_control_nway.sv - randomized self-checking bench for cache_control_nway
module tb_cache_control_nway;

  localparam int N = 4;
  localparam int W = 2;
  localparam logic [N-1:0] F = 4'hF;

  localparam int P_IDLE = 0;
  localparam int P_WB   = 1;
  localparam int P_AL   = 2;
  localparam int P_ER   = 3;

  logic clk;
  logic rst;
  logic mem_read, mem_write;
  logic [N-1:0] hit, valid_out, dirty_out;
  logic pmem_resp, pmem_error;
  logic arrays_read;
  logic [N-1:0] dirty_load, dirty_in, valid_load, valid_in, tag_load, data_array_mux_sel;
  logic [2*N-1:0] mem_mask_mux_sel;
  logic pmem_addr_mux_sel;
  logic [W-1:0] victim_way;
  logic mem_resp, mem_error, pmem_read, pmem_write;

  cache_control_nway #(.NUM_WAYS(N)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .valid_out(valid_out), .dirty_out(dirty_out),
    .pmem_resp(pmem_resp), .pmem_error(pmem_error), .arrays_read(arrays_read),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .valid_load(valid_load),
    .valid_in(valid_in), .tag_load(tag_load), .data_array_mux_sel(data_array_mux_sel),
    .mem_mask_mux_sel(mem_mask_mux_sel), .pmem_addr_mux_sel(pmem_addr_mux_sel),
    .victim_way(victim_way), .mem_resp(mem_resp), .mem_error(mem_error),
    .pmem_read(pmem_read), .pmem_write(pmem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // Reference model: phase of the outstanding miss, victim, and per-way last-use
  // timestamps (the pseudo-LRU tree always steers toward the half whose most
  // recent use is older; an untouched pair resolves to the lower half).
  int ph = P_IDLE;
  int m_victim = 0;
  int m_rr = 0;
  int stamp[N];
  int now_t = 0;

  function automatic int policy_way();
`ifdef CACHE_CTRL_PLRU_EN
    int lo, size, half, ml, mr;
    lo = 0;
    size = N;
    while (size > 1) begin
      half = size / 2;
      ml = 0;
      mr = 0;
      for (int i = 0; i < half; i++) begin
        if (stamp[lo+i] > ml) ml = stamp[lo+i];
        if (stamp[lo+half+i] > mr) mr = stamp[lo+half+i];
      end
      if (mr < ml) lo = lo + half;
      size = half;
    end
    return lo;
`else
    return m_rr;
`endif
  endfunction

  function automatic int way_of(input logic [N-1:0] h);
    int w = 0;
    for (int i = 0; i < N; i++) if (h[i]) w = i;
    return w;
  endfunction

  task automatic touch(input int w);
    now_t++;
    stamp[w] = now_t;
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_dl, e_di, e_vl, e_vi, e_tl, e_ds;
    logic [2*N-1:0] e_mk;
    logic e_rd, e_wr, e_as, e_resp, e_err;
    bool_reset(e_dl, e_di, e_vl, e_vi, e_tl, e_ds);
    e_mk = '0; e_rd = 0; e_wr = 0; e_as = 0; e_resp = 0; e_err = 0;
    if (!rst) begin
      case (ph)
        P_IDLE: begin
          if (mem_read && hit != 0) begin
            e_resp = 1;
          end else if (mem_write && hit != 0) begin
            e_resp = 1;
            e_dl[way_of(hit)] = 1;
            e_di[way_of(hit)] = 1;
            e_ds[way_of(hit)] = 1;
            e_mk[2*way_of(hit) +: 2] = 2'd2;
          end
        end
        P_WB: begin
          e_wr = 1;
          e_as = 1;
          if (pmem_resp && !pmem_error) e_dl[m_victim] = 1;
        end
        P_AL: begin
          e_rd = 1;
          if (pmem_resp && !pmem_error) begin
            e_tl[m_victim] = 1;
            e_vl[m_victim] = 1;
            e_vi[m_victim] = 1;
            e_dl[m_victim] = 1;
            e_mk[2*m_victim +: 2] = 2'd1;
          end
        end
        default: begin
          e_resp = 1;
          e_err = 1;
        end
      endcase
    end
    check("arrays_read", arrays_read, 1);
    check("resp_err", {mem_resp, mem_error}, {e_resp, e_err});
    check("pmem", {pmem_read, pmem_write, pmem_addr_mux_sel}, {e_rd, e_wr, e_as});
    check("dirty", {dirty_load, dirty_in}, {e_dl, e_di});
    check("valid_tag", {valid_load, valid_in, tag_load}, {e_vl, e_vi, e_tl});
    check("data_mask", {data_array_mux_sel, mem_mask_mux_sel}, {e_ds, e_mk});
    check("victim", victim_way, m_victim);
  endtask

  task automatic bool_reset(output logic [N-1:0] a, b, c, d, e, f);
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0;
  endtask

  task automatic model_tick();
    int v;
    if (rst) begin
      ph = P_IDLE;
      m_victim = 0;
      m_rr = 0;
      now_t = 0;
      for (int i = 0; i < N; i++) stamp[i] = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          if ((mem_read || mem_write) && hit != 0) begin
            touch(way_of(hit));
          end else if (mem_read || mem_write) begin
            v = -1;
            for (int i = 0; i < N; i++) if (!valid_out[i] && v < 0) v = i;
            if (v < 0) v = policy_way();
            m_victim = v;
            ph = (valid_out[v] && dirty_out[v]) ? P_WB : P_AL;
          end
        end
        P_WB: begin
          if (pmem_error) ph = P_ER;
          else if (pmem_resp) ph = P_AL;
        end
        P_AL: begin
          if (pmem_error) ph = P_ER;
          else if (pmem_resp) begin
            touch(m_victim);
            m_rr = (m_rr + 1) % N;
            ph = P_IDLE;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit rd, input bit wr, input logic [N-1:0] h,
                       input logic [N-1:0] v, input logic [N-1:0] d, input bit presp, input bit perr);
    @(negedge clk);
    rst = r; mem_read = rd; mem_write = wr; hit = h;
    valid_out = v; dirty_out = d; pmem_resp = presp; pmem_error = perr;
    #1;
    cyc_n++;
    check_cycle();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic cyc(input bit r, input bit rd, input bit wr, input logic [N-1:0] h,
                     input logic [N-1:0] v, input logic [N-1:0] d, input bit presp, input bit perr);
    drive(r, rd, wr, h, v, d, presp, perr);
    tick();
  endtask

  int exp_v;

  initial begin
    for (int i = 0; i < N; i++) stamp[i] = 0;
    rst = 1; mem_read = 0; mem_write = 0; hit = 0; valid_out = 0; dirty_out = 0;
    pmem_resp = 0; pmem_error = 0;

    cyc(1, 1, 0, 0, F, F, 1, 0);
    cyc(1, 0, 0, 0, F, 0, 0, 0);
    drive(0, 0, 0, 0, F, 0, 0, 0);
    check("rst_victim", victim_way, 0);
    check("rst_idle_resp", mem_resp, 0);
    tick();

    // read hit way 2
    drive(0, 1, 0, 4'b0100, F, 0, 0, 0);
    check("rdhit_resp", mem_resp, 1);
    check("rdhit_noload", {dirty_load, valid_load, tag_load}, 0);
    tick();

    // write hit way 3
    drive(0, 0, 1, 4'b1000, F, 0, 0, 0);
    check("wrhit_dirty", {dirty_load[3], dirty_in[3]}, 2'b11);
    check("wrhit_mask", mem_mask_mux_sel[7:6], 2);
    check("wrhit_resp", mem_resp, 1);
    tick();

    // clean miss with way 3 invalid; fill completes in 5th ALLOCATE cycle
    cyc(0, 1, 0, 0, 4'b0111, 0, 0, 0);
    drive(0, 1, 0, 0, 4'b0111, 0, 0, 0);
    check("miss_victim", victim_way, 3);
    check("alloc_read", pmem_read, 1);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 4'b0111, 0, 0, 0);
    drive(0, 1, 0, 0, 4'b0111, 0, 1, 0);
    check("fill_tag", tag_load, 4'b1000);
    check("fill_valid", valid_load, 4'b1000);
    tick();
    drive(0, 1, 0, 4'b1000, F, 0, 0, 0);
    check("post_fill_resp", mem_resp, 1);
    tick();

    // touch ways 0..3, then dirty miss with all ways valid
    for (int w = 0; w < N; w++) cyc(0, 1, 0, 4'(1 << w), F, F, 0, 0);
`ifdef CACHE_CTRL_PLRU_EN
    exp_v = 0;
`else
    exp_v = 1;
`endif
    cyc(0, 0, 1, 0, F, F, 0, 0);
    drive(0, 0, 1, 0, F, F, 1, 0);
    check("dirty_victim", victim_way, exp_v);
    check("wb_write", {pmem_write, pmem_addr_mux_sel}, 2'b11);
    check("wb_clear", {dirty_load, dirty_in}, {4'(1 << exp_v), 4'b0000});
    tick();
    drive(0, 0, 1, 0, F, F, 1, 0);
    check("wb_alloc_tag", tag_load, 4'(1 << exp_v));
    tick();

    // pmem_error (with simultaneous resp) in cycle 2 of ALLOCATE
    cyc(0, 1, 0, 0, 4'b0111, 0, 0, 0);
    cyc(0, 1, 0, 0, 4'b0111, 0, 0, 0);
    drive(0, 1, 0, 0, 4'b0111, 0, 1, 1);
    check("err_noload", {tag_load, valid_load, dirty_load}, 0);
    tick();
    drive(0, 1, 0, 0, F, 0, 0, 0);
    check("err_resp", {mem_resp, mem_error}, 2'b11);
    tick();
    drive(0, 0, 0, 0, F, 0, 0, 0);
    check("err_back_idle", {mem_resp, mem_error, pmem_read}, 0);
    tick();

    // reset in the middle of a writeback
    cyc(0, 1, 0, 0, F, F, 0, 0);
    cyc(0, 1, 0, 0, F, F, 0, 0);
    drive(1, 1, 0, 0, F, F, 0, 0);
    check("rst_wb_write", pmem_write, 0);
    tick();
    drive(0, 0, 0, 0, F, 0, 0, 0);
    check("after_rst_write", pmem_write, 0);
    check("after_rst_victim", victim_way, 0);
    tick();
    cyc(0, 1, 0, 0, F, 0, 0, 0);
    drive(0, 1, 0, 0, F, 0, 1, 0);
    check("after_rst_policy", victim_way, 0);
    check("after_rst_fill", tag_load, 4'b0001);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] h, v, d;
      h = ($urandom_range(0, 1) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      v = ($urandom_range(0, 1) != 0) ? F : 4'($urandom());
      d = 4'($urandom());
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
          h, v, d, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
